// File: rtl/apb_master_bridge_if.sv
// ---------------------------------------------------------------------------
// apb_master_bridge_if
// Purpose : bundles the CPU-side request/response handshake and the APB3 bus
//           seen by apb_master_bridge into a single interface.
// Signals :
//   CPU side : APBMASTERENABLE, CPUSEL, addr, data, CPUWRITE (requests in)
//              CPUREADY, CPURDATA, CPUERR (completion out)
//   APB side : PSEL, PENABLE, PWRITE, PADDR, PWDATA (bridge drives)
//              PRDATA, PREADY, PSLVERR (slaves drive)
// Modports:
//   master : the bridge's view
//   slave  : the environment's view (CPU and APB slaves)
// ---------------------------------------------------------------------------
interface apb_master_bridge_if #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int NUM_SLAVES = 4
);

  // CPU request / response
  logic                  APBMASTERENABLE;
  logic [ADDR_W-1:0]     CPUSEL;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     data;
  logic                  CPUWRITE;
  logic                  CPUREADY;
  logic [DATA_W-1:0]     CPURDATA;
  logic                  CPUERR;

  // APB3 bus
  logic [NUM_SLAVES-1:0] PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_W-1:0]     PADDR;
  logic [DATA_W-1:0]     PWDATA;
  logic [DATA_W-1:0]     PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  APBMASTERENABLE, CPUSEL, addr, data, CPUWRITE,
    input  PRDATA, PREADY, PSLVERR,
    output CPUREADY, CPURDATA, CPUERR,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output APBMASTERENABLE, CPUSEL, addr, data, CPUWRITE,
    output PRDATA, PREADY, PSLVERR,
    input  CPUREADY, CPURDATA, CPUERR,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
// Purpose : APB3 master stage. Turns one CPU request into one APB
//           SETUP/ACCESS transfer, decodes CPUSEL into a one-hot PSEL, waits
//           for PREADY (or aborts after TIMEOUT ACCESS cycles) and returns a
//           one-cycle CPUREADY pulse with read data and error status.
// Ports   :
//   clk      in  single rising-edge clock
//   PRESETn  in  asynchronous active-low reset
//   bus      apb_master_bridge_if.master
//            CPU side  : APBMASTERENABLE/CPUSEL/addr/data/CPUWRITE in,
//                        CPUREADY/CPURDATA/CPUERR out
//            APB side  : PSEL/PENABLE/PWRITE/PADDR/PWDATA out,
//                        PRDATA/PREADY/PSLVERR in
// All outputs are registered.
// ---------------------------------------------------------------------------
module apb_master_bridge #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int NUM_SLAVES = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                 clk,
  input  logic                 PRESETn,
  apb_master_bridge_if.master  bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                state_q,    state_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;
  logic [NUM_SLAVES-1:0] psel_q,     psel_d;
  logic                  penable_q,  penable_d;
  logic                  pwrite_q,   pwrite_d;
  logic [ADDR_W-1:0]     paddr_q,    paddr_d;
  logic [DATA_W-1:0]     pwdata_q,   pwdata_d;
  logic                  cpuready_q, cpuready_d;
  logic [DATA_W-1:0]     cpurdata_q, cpurdata_d;
  logic                  cpuerr_q,   cpuerr_d;

  logic [NUM_SLAVES-1:0] sel_onehot;

  // One-hot decode of the requested slave; an all-zero result means the
  // index is out of range, so validity falls out of the decode for free.
  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (bus.CPUSEL == ADDR_W'(i)) begin
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // Next-state and next-output logic. The completion outputs default to 0
  // so CPUREADY is a single-cycle pulse and CPURDATA/CPUERR are only
  // non-zero alongside it. PADDR/PWDATA/PWRITE are loaded on the capture
  // edge so they are already valid during SETUP, and simply hold afterwards.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    cpuready_d = 1'b0;
    cpurdata_d = '0;
    cpuerr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // A request still high during the CPUREADY cycle is the one that
        // just finished, so it must not be taken again.
        if (bus.APBMASTERENABLE && !cpuready_q) begin
          if (|sel_onehot) begin
            psel_d   = sel_onehot;
            paddr_d  = bus.addr;
            pwdata_d = bus.data;
            pwrite_d = bus.CPUWRITE;
            state_d  = SETUP;
          end else begin
            cpuready_d = 1'b1;
            cpuerr_d   = 1'b1;
          end
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end

      ACCESS: begin
        // PREADY is tested first so a response in the last allowed cycle
        // completes normally instead of being reported as a timeout.
        if (bus.PREADY) begin
          psel_d     = '0;
          penable_d  = 1'b0;
          cpuready_d = 1'b1;
          cpuerr_d   = bus.PSLVERR;
          cpurdata_d = pwrite_q ? '0 : bus.PRDATA;
          cnt_d      = '0;
          state_d    = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          psel_d     = '0;
          penable_d  = 1'b0;
          cpuready_d = 1'b1;
          cpuerr_d   = 1'b1;
          cnt_d      = '0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        psel_d    = '0;
        penable_d = 1'b0;
        cnt_d     = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops everything to 0 immediately,
  // including mid-transfer, without producing a completion pulse.
  always_ff @(posedge clk or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      psel_q     <= '0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      cpuready_q <= 1'b0;
      cpurdata_q <= '0;
      cpuerr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      cpuready_q <= cpuready_d;
      cpurdata_q <= cpurdata_d;
      cpuerr_q   <= cpuerr_d;
    end
  end

  assign bus.PSEL     = psel_q;
  assign bus.PENABLE  = penable_q;
  assign bus.PWRITE   = pwrite_q;
  assign bus.PADDR    = paddr_q;
  assign bus.PWDATA   = pwdata_q;
  assign bus.CPUREADY = cpuready_q;
  assign bus.CPURDATA = cpurdata_q;
  assign bus.CPUERR   = cpuerr_q;

endmodule
